// File: rtl/sobel_frame_ctrl_if.sv
// Handshake/status bundle between a frame source and sobel_frame_ctrl.
// Optional statistics signals exist only when SOBEL_FRAME_CTRL_STATS_EN is defined.
interface sobel_frame_ctrl_if #(
  parameter int CW = 10
);
  logic          start;
  logic [CW-1:0] cfg_cols;
  logic [CW-1:0] cfg_rows;
  logic          in_valid;
  logic          in_ready;
  logic          shift_en;
  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic          on_edge;
  logic          out_valid;
  logic          busy;
  logic          frame_done;
  logic          cfg_err;
`ifdef SOBEL_FRAME_CTRL_STATS_EN
  logic [15:0]   frame_count;
  logic [15:0]   stall_count;

  modport master (
    output start, cfg_cols, cfg_rows, in_valid,
    input  in_ready, shift_en, col, row, on_edge, out_valid,
    input  busy, frame_done, cfg_err, frame_count, stall_count
  );
  modport slave (
    input  start, cfg_cols, cfg_rows, in_valid,
    output in_ready, shift_en, col, row, on_edge, out_valid,
    output busy, frame_done, cfg_err, frame_count, stall_count
  );
`else
  modport master (
    output start, cfg_cols, cfg_rows, in_valid,
    input  in_ready, shift_en, col, row, on_edge, out_valid,
    input  busy, frame_done, cfg_err
  );
  modport slave (
    input  start, cfg_cols, cfg_rows, in_valid,
    output in_ready, shift_en, col, row, on_edge, out_valid,
    output busy, frame_done, cfg_err
  );
`endif
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for a 3x3 Sobel core: accepts windows in raster order,
// tracks col/row, flags border pixels and mirrors the core's 2-stage latency.
// Optional macro SOBEL_FRAME_CTRL_STATS_EN adds frame_count / stall_count.
module sobel_frame_ctrl #(
  parameter int CW = 10
) (
  input  logic              clock,
  input  logic              reset_n,
  sobel_frame_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [CW-1:0] MIN_DIM = CW'(3);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cols_q, cols_d;
  logic [CW-1:0] rows_q, rows_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic          on_edge_q, on_edge_d;
  logic          v1_q, out_valid_q;
  logic          frame_done_q, frame_done_d;
  logic          cfg_err_q, cfg_err_d;

  logic accept, last_col, last_row, cfg_ok, start_ok;

  assign cfg_ok   = (bus.cfg_cols >= MIN_DIM) && (bus.cfg_rows >= MIN_DIM);
  assign start_ok = (state_q == S_IDLE) && bus.start && cfg_ok;
  assign accept   = bus.in_valid && (state_q == S_RUN);
  assign last_col = (col_q == (cols_q - ONE));
  assign last_row = (row_q == (rows_q - ONE));

  // Border flag is captured from the coordinate being accepted and held between accepts.
  assign on_edge_d = accept ? ((col_q == '0) || last_col || (row_q == '0) || last_row)
                            : on_edge_q;

  // Next-state logic: start/config in IDLE, raster advance in RUN, pipeline flush in DRAIN.
  always_comb begin
    state_d      = state_q;
    cols_d       = cols_q;
    rows_d       = rows_q;
    col_d        = col_q;
    row_d        = row_q;
    frame_done_d = 1'b0;
    cfg_err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (cfg_ok) begin
            cols_d  = bus.cfg_cols;
            rows_d  = bus.cfg_rows;
            col_d   = '0;
            row_d   = '0;
            state_d = S_RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (accept) begin
          if (last_col) begin
            if (last_row) begin
              // Final pixel: coordinates freeze at (cols-1, rows-1).
              state_d = S_DRAIN;
            end else begin
              col_d = '0;
              row_d = row_q + ONE;
            end
          end else begin
            col_d = col_q + ONE;
          end
        end
      end
      S_DRAIN: begin
        // No accepts happen here, so once v1 is empty both stages are empty
        // after this edge; frame_done lands right after the last out_valid.
        if (!v1_q) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, latched configuration, coordinates and status pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cols_q       <= '0;
      rows_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      on_edge_q    <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cols_q       <= cols_d;
      rows_q       <= rows_d;
      col_q        <= col_d;
      row_q        <= row_d;
      on_edge_q    <= on_edge_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  // Valid pipeline matching the Sobel core's two register stages.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      v1_q        <= accept;
      out_valid_q <= v1_q;
    end
  end

  assign bus.in_ready   = (state_q == S_RUN);
  assign bus.shift_en   = accept;
  assign bus.col        = col_q;
  assign bus.row        = row_q;
  assign bus.on_edge    = on_edge_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.frame_done = frame_done_q;
  assign bus.cfg_err    = cfg_err_q;

`ifdef SOBEL_FRAME_CTRL_STATS_EN
  logic [15:0] frame_count_q;
  logic [15:0] stall_count_q;

  // Frame counter wraps; stall counter saturates and restarts with each accepted frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      if (frame_done_d) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
      if (start_ok) begin
        stall_count_q <= '0;
      end else if ((state_q == S_RUN) && !bus.in_valid && (stall_count_q != 16'hFFFF)) begin
        stall_count_q <= stall_count_q + 16'd1;
      end
    end
  end

  assign bus.frame_count = frame_count_q;
  assign bus.stall_count = stall_count_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed testbench for sobel_frame_ctrl (default build; stats checks only when
// SOBEL_FRAME_CTRL_STATS_EN is defined).
module tb_sobel_frame_ctrl;
  localparam int CW = 10;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  sobel_frame_ctrl_if #(.CW(CW)) bus ();
  sobel_frame_ctrl #(.CW(CW)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  int tests = 0;
  int fails = 0;

  // Per-frame recording filled by run_frame
  int n_acc, n_ov, n_fd, n_low, fd_cyc;
  int acc_cyc [64];
  int acc_col [64];
  int acc_row [64];
  int ov_cyc  [64];
  logic edge_at [64];
  logic [CW-1:0] fin_col, fin_row;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // mode 0: in_valid always high; mode 1: toggles starting high; mode 2: as 0 plus a 6x6 start at cycle 2
  task automatic run_frame(input int c, input int r, input int mode);
    bit prev_acc;
    int prev_idx;
    n_acc = 0; n_ov = 0; n_fd = 0; n_low = 0; fd_cyc = -1;
    prev_acc = 0; prev_idx = 0;
    fin_col = '0; fin_row = '0;
    bus.cfg_cols = c[CW-1:0];
    bus.cfg_rows = r[CW-1:0];
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      bus.in_valid = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
      if (mode == 2 && cyc == 2) begin
        bus.start = 1'b1; bus.cfg_cols = 10'd6; bus.cfg_rows = 10'd6;
      end else begin
        bus.start = 1'b0;
      end
      #1;
      if (prev_acc && prev_idx < 64) edge_at[prev_idx] = bus.on_edge;
      prev_acc = 0;
      if (bus.in_ready && !bus.in_valid) n_low++;
      if (bus.shift_en) begin
        if (n_acc < 64) begin
          acc_cyc[n_acc] = cyc; acc_col[n_acc] = int'(bus.col); acc_row[n_acc] = int'(bus.row);
        end
        prev_acc = 1; prev_idx = n_acc; n_acc++;
      end
      if (bus.out_valid) begin
        if (n_ov < 64) ov_cyc[n_ov] = cyc;
        n_ov++;
      end
      if (bus.frame_done) begin
        if (n_fd == 0) begin
          fd_cyc = cyc; fin_col = bus.col; fin_row = bus.row;
        end
        n_fd++;
      end
      if (n_fd > 0 && cyc > fd_cyc + 3) break;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%0b want=0", bus.busy); end
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%0b want=0", bus.in_ready); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%0b want=0", bus.out_valid); end
    tests++; if ({bus.col, bus.row} !== {2*CW{1'b0}}) begin fails++; $display("FAIL reset_colrow got=%0d,%0d want=0,0", bus.col, bus.row); end
    tests++; if ({bus.on_edge, bus.frame_done, bus.cfg_err} !== 3'b000) begin fails++; $display("FAIL reset_flags got=%b want=000", {bus.on_edge, bus.frame_done, bus.cfg_err}); end
    reset_n = 1'b1;
    tick();
    $display("[TB] reset: busy=%0b col=%0d row=%0d", bus.busy, bus.col, bus.row);
  endtask

  task automatic test_frame_4x3();
    logic [11:0] exp_edges, got_edges;
    int bad;
    exp_edges = 12'b1111_1001_1111;
    run_frame(4, 3, 0);
    got_edges = '0; bad = 0;
    for (int i = 0; i < 12; i++) begin
      got_edges[i] = edge_at[i];
      if (acc_col[i] != i % 4 || acc_row[i] != i / 4) bad++;
      if (ov_cyc[i] != acc_cyc[i] + 2) bad++;
    end
    tests++; if (n_acc !== 12) begin fails++; $display("FAIL f4x3_accepts got=%0d want=12", n_acc); end
    tests++; if (n_ov !== 12) begin fails++; $display("FAIL f4x3_out_valid_count got=%0d want=12", n_ov); end
    tests++; if (ov_cyc[0] !== 2 || ov_cyc[11] !== 13) begin fails++; $display("FAIL f4x3_ov_window got=%0d..%0d want=2..13", ov_cyc[0], ov_cyc[11]); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL f4x3_raster_latency got=%0d bad want=0", bad); end
    tests++; if (fd_cyc !== 14 || n_fd !== 1) begin fails++; $display("FAIL f4x3_frame_done got=cyc%0d x%0d want=cyc14 x1", fd_cyc, n_fd); end
    tests++; if (got_edges !== exp_edges) begin fails++; $display("FAIL f4x3_on_edge got=%b want=%b", got_edges, exp_edges); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL f4x3_busy_after got=%0b want=0", bus.busy); end
    $display("[TB] frame 4x3: accepts=%0d out_valid=%0d frame_done@%0d", n_acc, n_ov, fd_cyc);
  endtask

  task automatic test_cfg_err();
    bus.cfg_cols = 10'd2; bus.cfg_rows = 10'd5; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tests++; if (bus.cfg_err !== 1'b1) begin fails++; $display("FAIL cfgerr_pulse got=%0b want=1", bus.cfg_err); end
    tests++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin fails++; $display("FAIL cfgerr_idle got=busy%0b rdy%0b want=00", bus.busy, bus.in_ready); end
    tick();
    tests++; if (bus.cfg_err !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL cfgerr_one_cycle got=err%0b busy%0b want=00", bus.cfg_err, bus.busy); end
    bus.cfg_cols = 10'd5; bus.cfg_rows = 10'd2; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tests++; if (bus.cfg_err !== 1'b1 || bus.in_ready !== 1'b0) begin fails++; $display("FAIL cfgerr_rows got=err%0b rdy%0b want=10", bus.cfg_err, bus.in_ready); end
    tick();
    $display("[TB] cfg_err: 2x5 and 5x2 rejected");
  endtask

  task automatic test_gaps_5x5();
    int bad;
    run_frame(5, 5, 1);
    bad = 0;
    for (int i = 0; i < 25; i++) if (ov_cyc[i] != acc_cyc[i] + 2 || acc_cyc[i] != 2 * i) bad++;
    tests++; if (n_acc !== 25) begin fails++; $display("FAIL gaps_accepts got=%0d want=25", n_acc); end
    tests++; if (n_ov !== 25) begin fails++; $display("FAIL gaps_out_valid got=%0d want=25", n_ov); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL gaps_timing got=%0d bad want=0", bad); end
    tests++; if (fin_col !== 10'd4 || fin_row !== 10'd4) begin fails++; $display("FAIL gaps_final got=%0d,%0d want=4,4", fin_col, fin_row); end
    tests++; if (n_fd !== 1) begin fails++; $display("FAIL gaps_frame_done got=%0d want=1", n_fd); end
`ifdef SOBEL_FRAME_CTRL_STATS_EN
    tests++; if (bus.stall_count !== 16'd24) begin fails++; $display("FAIL gaps_stall_count got=%0d want=24", bus.stall_count); end
    tests++; if (bus.frame_count !== 16'd2) begin fails++; $display("FAIL gaps_frame_count got=%0d want=2", bus.frame_count); end
`endif
    $display("[TB] frame 5x5 gaps: accepts=%0d out_valid=%0d low=%0d", n_acc, n_ov, n_low);
  endtask

  task automatic test_start_ignored();
    run_frame(4, 3, 2);
    tests++; if (n_acc !== 12 || n_ov !== 12) begin fails++; $display("FAIL ign_counts got=%0d/%0d want=12/12", n_acc, n_ov); end
    tests++; if (fin_col !== 10'd3 || fin_row !== 10'd2 || n_fd !== 1) begin fails++; $display("FAIL ign_final got=%0d,%0d fd%0d want=3,2 fd1", fin_col, fin_row, n_fd); end
    $display("[TB] start during RUN: accepts=%0d final=%0d,%0d", n_acc, fin_col, fin_row);
  endtask

  task automatic test_reset_midframe();
    logic [8:0] exp_edges, got_edges;
    int seen;
    bus.cfg_cols = 10'd8; bus.cfg_rows = 10'd8; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.in_valid = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    tests++; if (bus.col !== 10'd7 || bus.out_valid !== 1'b1) begin fails++; $display("FAIL mid_before got=col%0d ov%0b want=col7 ov1", bus.col, bus.out_valid); end
    reset_n = 1'b0; bus.in_valid = 1'b0;
    #1;
    tests++; if ({bus.out_valid, bus.busy, bus.in_ready, bus.on_edge, bus.frame_done} !== 5'b0) begin fails++; $display("FAIL mid_reset_flags got=%b want=00000", {bus.out_valid, bus.busy, bus.in_ready, bus.on_edge, bus.frame_done}); end
    tests++; if (bus.col !== 10'd0 || bus.row !== 10'd0) begin fails++; $display("FAIL mid_reset_colrow got=%0d,%0d want=0,0", bus.col, bus.row); end
    seen = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (bus.frame_done || bus.out_valid) seen++; end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); if (bus.frame_done || bus.out_valid) seen++; end
    tests++; if (seen !== 0) begin fails++; $display("FAIL mid_no_done got=%0d want=0", seen); end
    run_frame(3, 3, 0);
    exp_edges = 9'b111_101_111;
    got_edges = '0;
    for (int i = 0; i < 9; i++) got_edges[i] = edge_at[i];
    tests++; if (n_acc !== 9 || n_ov !== 9 || n_fd !== 1) begin fails++; $display("FAIL mid_3x3 got=%0d/%0d/%0d want=9/9/1", n_acc, n_ov, n_fd); end
    tests++; if (got_edges !== exp_edges) begin fails++; $display("FAIL mid_3x3_edge got=%b want=%b", got_edges, exp_edges); end
    $display("[TB] reset mid-frame then 3x3: accepts=%0d out_valid=%0d", n_acc, n_ov);
  endtask

  initial begin
    bus.start = 1'b0; bus.cfg_cols = '0; bus.cfg_rows = '0; bus.in_valid = 1'b0;
    test_reset();
    test_frame_4x3();
    test_cfg_err();
    test_gaps_5x5();
    test_start_ignored();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
